// File: rtl/store_commit_buffer_if.sv
// rtl/store_commit_buffer_if.sv - commit and data-memory write bus of the store commit buffer
interface store_commit_buffer_if;
  // commit side (reorder buffer -> buffer)
  logic        commitValid;
  logic [31:0] commitAddr;
  logic [31:0] commitData;
  logic [2:0]  commitType;
  logic        full;
  // data-memory write side (buffer -> memory)
  logic        memReq;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic [3:0]  memByteEn;
  logic        memAck;

  // environment view: drives commits and acknowledges writes
  modport master (
    output commitValid, commitAddr, commitData, commitType, memAck,
    input  full, memReq, memAddr, memData, memByteEn
  );

  // buffer view
  modport slave (
    input  commitValid, commitAddr, commitData, commitType, memAck,
    output full, memReq, memAddr, memData, memByteEn
  );
endinterface

// File: rtl/store_commit_buffer.sv
// rtl/store_commit_buffer.sv - in-order committed-store FIFO draining to data memory
module store_commit_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  store_commit_buffer_if.slave bus,
  input  logic [31:0]          loadCheckAddr,
  output logic                 loadConflict,
  output logic                 empty,
  output logic                 errOverflow,
  output logic                 errMisalign
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  state_t           state_q;
  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_nxt;

  logic [1:0]  lane;
  logic        fmt_ok;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_data;
  logic        enq;
  logic        pop;
  logic        unused_lca;

  assign lane       = bus.commitAddr[1:0];
  // the low byte-offset bits of a load never matter for a word-granular check
  assign unused_lca = ^loadCheckAddr[1:0];

  // Lane formatting of the incoming store and legality of its type/alignment
  always_comb begin
    fmt_ok   = 1'b0;
    fmt_be   = 4'b0000;
    fmt_data = bus.commitData;
    case (bus.commitType)
      3'b000: begin
        fmt_ok   = 1'b1;
        fmt_be   = 4'b0001 << lane;
        fmt_data = {4{bus.commitData[7:0]}};
      end
      3'b001: begin
        fmt_ok   = ~lane[0];
        fmt_be   = 4'b0011 << {lane[1], 1'b0};
        fmt_data = {2{bus.commitData[15:0]}};
      end
      3'b010: begin
        fmt_ok = (lane == 2'b00);
        fmt_be = 4'b1111;
      end
      default: ;
    endcase
  end

  // Enqueue is judged against the registered full flag, so a same-cycle pop never rescues a commit
  assign enq       = bus.commitValid && !bus.full && fmt_ok;
  assign pop       = (state_q == REQ) && bus.memAck;
  assign count_nxt = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);

  // Entry storage; only occupancy is reset, payload contents are don't-care until written
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= bus.commitAddr[31:2];
      data_q[tail_q] <= fmt_data;
      be_q[tail_q]   <= fmt_be;
    end
  end

  // Pointers, occupancy flags, sticky errors and the drain state machine
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      state_q       <= IDLE;
      bus.memReq    <= 1'b0;
      bus.memAddr   <= '0;
      bus.memData   <= '0;
      bus.memByteEn <= '0;
      bus.full      <= 1'b0;
      empty         <= 1'b1;
      errOverflow   <= 1'b0;
      errMisalign   <= 1'b0;
    end else begin
      if (enq) tail_q <= tail_q + PTR_W'(1);
      if (pop) head_q <= head_q + PTR_W'(1);
      count_q  <= count_nxt;
      bus.full <= (count_nxt == DEPTH_C);
      empty    <= (count_nxt == '0);

      if (bus.commitValid && bus.full)  errOverflow <= 1'b1;
      else if (bus.commitValid && !fmt_ok) errMisalign <= 1'b1;

      case (state_q)
        IDLE: begin
          // count_q excludes this cycle's enqueue, so a fresh entry waits one cycle
          if (count_q != '0) begin
            bus.memAddr   <= {addr_q[head_q], 2'b00};
            bus.memData   <= data_q[head_q];
            bus.memByteEn <= be_q[head_q];
            bus.memReq    <= 1'b1;
            state_q       <= REQ;
          end
        end
        REQ: begin
          // returning to IDLE on ack leaves a one-cycle bubble between writes
          if (bus.memAck) begin
            bus.memReq <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Word-address match against every occupied slot, including the one being written out
  always_comb begin
    loadConflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PTR_W'(i) - head_q} < count_q) && (addr_q[i] == loadCheckAddr[31:2]))
        loadConflict = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_commit_buffer.sv
// tb/tb_store_commit_buffer.sv - self-checking bench for store_commit_buffer
module tb_store_commit_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    bit          ok;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [3:0]  eb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] lca = '0;
  logic        conflict, empty, ovf, mis;

  store_commit_buffer_if bus();

  store_commit_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .loadCheckAddr(lca),
    .loadConflict(conflict), .empty(empty), .errOverflow(ovf), .errMisalign(mis)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  wr_t mq[$];
  wr_t got[$];
  bit  m_req, m_ovf, m_mis;
  wr_t m_cur;
  vec_t vec[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Store formatting from the architectural rules: byte lane = addr mod 4
  task automatic fmt(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                     output bit ok, output wr_t w);
    int off;
    off    = int'(a % 4);
    w.addr = a - 32'(off);
    ok     = 0;
    w.be   = 0;
    w.data = d;
    if (t == 3'd0) begin
      ok = 1; w.be = 4'(1 << off); w.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
    end else if (t == 3'd1) begin
      ok = (off % 2 == 0); w.be = 4'(3 << off); w.data = {d[15:0], d[15:0]};
    end else if (t == 3'd2) begin
      ok = (off == 0); w.be = 4'hF;
    end
  endtask

  // Reference: queue of pending stores plus one outstanding memory request
  task automatic model_step(input bit rn, input bit v, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] t, input bit ack);
    int  n_before;
    bit  ok;
    wr_t w;
    if (!rn) begin
      mq.delete(); m_req = 0; m_ovf = 0; m_mis = 0;
      return;
    end
    n_before = mq.size();
    if (m_req && ack) begin
      void'(mq.pop_front());
      m_req = 0;
    end else if (!m_req && n_before > 0) begin
      m_req = 1;
      m_cur = mq[0];
    end
    if (v) begin
      fmt(a, d, t, ok, w);
      if (n_before == DEPTH) m_ovf = 1;
      else if (!ok) m_mis = 1;
      else mq.push_back(w);
    end
  endtask

  function automatic bit model_conflict(input logic [31:0] la);
    foreach (mq[i]) if ((mq[i].addr >> 2) == (la >> 2)) return 1;
    return 0;
  endfunction

  task automatic tick();
    bit rn, v, ack;
    logic [31:0] a, d;
    logic [2:0] t;
    rn = rst_n; v = bus.commitValid; a = bus.commitAddr; d = bus.commitData;
    t = bus.commitType; ack = bus.memAck;
    @(posedge clk);
    model_step(rn, v, a, d, t, ack);
    #1;
  endtask

  task automatic idle_inputs();
    bus.commitValid = 0; bus.commitAddr = 0; bus.commitData = 0; bus.commitType = 0;
  endtask

  task automatic commit(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    bus.commitValid = 1; bus.commitType = t; bus.commitAddr = a; bus.commitData = d;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.memAck = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic collect(input int n);
    wr_t w;
    repeat (n) begin
      if (bus.memReq && bus.memAck) begin
        w.addr = bus.memAddr; w.data = bus.memData; w.be = bus.memByteEn;
        got.push_back(w);
      end
      tick();
    end
  endtask

  initial begin
    int  w;
    bit  saw;
    vec[0]  = '{3'd2, 32'h100, 32'hDEADBEEF, 1, 32'h100, 32'hDEADBEEF, 4'hF};
    vec[1]  = '{3'd0, 32'h203, 32'h000000AB, 1, 32'h200, 32'hABABABAB, 4'h8};
    vec[2]  = '{3'd0, 32'h200, 32'h123456CD, 1, 32'h200, 32'hCDCDCDCD, 4'h1};
    vec[3]  = '{3'd0, 32'h3F1, 32'h000000EF, 1, 32'h3F0, 32'hEFEFEFEF, 4'h2};
    vec[4]  = '{3'd1, 32'h206, 32'h00001234, 1, 32'h204, 32'h12341234, 4'hC};
    vec[5]  = '{3'd1, 32'h040, 32'hABCD5678, 1, 32'h040, 32'h56785678, 4'h3};
    vec[6]  = '{3'd2, 32'h101, 32'h11111111, 0, 32'h0, 32'h0, 4'h0};
    vec[7]  = '{3'd1, 32'h203, 32'h00002222, 0, 32'h0, 32'h0, 4'h0};
    vec[8]  = '{3'd1, 32'h201, 32'h00003333, 0, 32'h0, 32'h0, 4'h0};
    vec[9]  = '{3'd2, 32'h102, 32'h44444444, 0, 32'h0, 32'h0, 4'h0};
    vec[10] = '{3'd3, 32'h100, 32'h55555555, 0, 32'h0, 32'h0, 4'h0};
    vec[11] = '{3'd7, 32'h100, 32'h66666666, 0, 32'h0, 32'h0, 4'h0};

    do_reset();
    chk("rst_memReq", bus.memReq, 0);
    chk("rst_memAddr", bus.memAddr, 0);
    chk("rst_memData", bus.memData, 0);
    chk("rst_memByteEn", bus.memByteEn, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_errOverflow", ovf, 0);
    chk("rst_errMisalign", mis, 0);

    // single-store formatting table
    for (int i = 0; i < 12; i++) begin
      do_reset();
      bus.memAck = 1;
      commit(vec[i].t, vec[i].a, vec[i].d);
      tick();
      idle_inputs();
      if (vec[i].ok) begin
        w = 0;
        while (!bus.memReq && w < 5) begin tick(); w++; end
        chk($sformatf("vec%0d_req", i), bus.memReq, 1);
        chk($sformatf("vec%0d_addr", i), bus.memAddr, vec[i].ea);
        chk($sformatf("vec%0d_data", i), bus.memData, vec[i].ed);
        chk($sformatf("vec%0d_be", i), bus.memByteEn, vec[i].eb);
        chk($sformatf("vec%0d_mis", i), mis, 0);
      end else begin
        saw = 0;
        repeat (3) begin tick(); saw |= bus.memReq; end
        chk($sformatf("vec%0d_noreq", i), saw, 0);
        chk($sformatf("vec%0d_mis", i), mis, 1);
        chk($sformatf("vec%0d_empty", i), empty, 1);
      end
    end

    // request latency and bubble with ack tied high
    do_reset();
    bus.memAck = 1;
    commit(3'd2, 32'h100, 32'hDEADBEEF);
    tick();
    idle_inputs();
    chk("t1_req_after_commit", bus.memReq, 0);
    chk("t1_notempty", empty, 0);
    tick();
    chk("t1_req", bus.memReq, 1);
    chk("t1_addr", bus.memAddr, 32'h100);
    chk("t1_data", bus.memData, 32'hDEADBEEF);
    chk("t1_be", bus.memByteEn, 4'hF);
    chk("t1_empty_in_req", empty, 0);
    tick();
    chk("t1_req_drop", bus.memReq, 0);
    chk("t1_empty_after", empty, 1);

    // two stores drain in commit order
    do_reset();
    bus.memAck = 1;
    got.delete();
    commit(3'd0, 32'h203, 32'h000000AB);
    tick();
    commit(3'd1, 32'h206, 32'h00001234);
    tick();
    idle_inputs();
    collect(8);
    chk("t2_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t2_w0_addr", got[0].addr, 32'h200);
      chk("t2_w0_data", got[0].data, 32'hABABABAB);
      chk("t2_w0_be", got[0].be, 4'h8);
      chk("t2_w1_addr", got[1].addr, 32'h204);
      chk("t2_w1_data", got[1].data, 32'h12341234);
      chk("t2_w1_be", got[1].be, 4'hC);
    end

    // overflow: fifth commit dropped while full
    do_reset();
    for (int i = 0; i < 5; i++) begin
      commit(3'd2, 32'h500 + 32'(4 * i), 32'(i));
      tick();
      if (i == 3) chk("t3_full_after4", bus.full, 1);
    end
    idle_inputs();
    chk("t3_overflow", ovf, 1);
    chk("t3_full", bus.full, 1);
    bus.memAck = 1;
    got.delete();
    collect(20);
    chk("t3_count", got.size(), 4);
    for (int j = 0; j < 4 && j < got.size(); j++) begin
      chk($sformatf("t3_w%0d_data", j), got[j].data, 32'(j));
      chk($sformatf("t3_w%0d_addr", j), got[j].addr, 32'h500 + 32'(4 * j));
    end
    chk("t3_empty", empty, 1);

    // load conflict visibility
    do_reset();
    commit(3'd2, 32'h300, 32'h0);
    lca = 32'h300;
    #1;
    chk("t4_same_cycle", conflict, 0);
    tick();
    idle_inputs();
    lca = 32'h302;
    #1;
    chk("t4_hit", conflict, 1);
    lca = 32'h304;
    #1;
    chk("t4_miss", conflict, 0);
    tick();
    lca = 32'h302;
    #1;
    chk("t4_hit_in_req", conflict, 1);
    bus.memAck = 1;
    tick();
    bus.memAck = 0;
    #1;
    chk("t4_after_ack", conflict, 0);

    // reset in the middle of a write
    do_reset();
    commit(3'd3, 32'h100, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      commit(3'd2, 32'h600 + 32'(4 * i), 32'hA0 + 32'(i));
      tick();
    end
    idle_inputs();
    chk("t6_pre_req", bus.memReq, 1);
    chk("t6_pre_mis", mis, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("t6_req", bus.memReq, 0);
    chk("t6_empty", empty, 1);
    chk("t6_mis", mis, 0);
    chk("t6_ovf", ovf, 0);
    chk("t6_full", bus.full, 0);
    bus.memAck = 1;
    saw = 0;
    repeat (10) begin tick(); saw |= bus.memReq; end
    chk("t6_no_writes", saw, 0);

    // randomized against the reference model: aligned phase, then anything goes
    for (int ph = 0; ph < 2; ph++) begin
      do_reset();
      for (int n = 0; n < 300; n++) begin
        logic [2:0]  t;
        logic [31:0] a;
        if (ph == 0) begin
          t = 3'($urandom_range(0, 2));
          a = 32'h1000 + 32'($urandom_range(0, 7) * 4);
          if (t == 3'd0) a = a + 32'($urandom_range(0, 3));
          if (t == 3'd1) a = a + 32'($urandom_range(0, 1) * 2);
        end else begin
          t = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
          a = 32'h1000 + 32'($urandom_range(0, 31));
        end
        bus.commitValid = ($urandom_range(0, 2) != 0);
        bus.commitType  = t;
        bus.commitAddr  = a;
        bus.commitData  = $urandom;
        bus.memAck      = (ph == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) < 3);
        lca             = 32'h1000 + 32'($urandom_range(0, 35));
        #1;
        chk("rnd_conflict", conflict, model_conflict(lca));
        tick();
        chk("rnd_req", bus.memReq, m_req);
        if (m_req) begin
          chk("rnd_addr", bus.memAddr, m_cur.addr);
          chk("rnd_data", bus.memData, m_cur.data);
          chk("rnd_be", bus.memByteEn, m_cur.be);
        end
        chk("rnd_full", bus.full, mq.size() == DEPTH);
        chk("rnd_empty", empty, mq.size() == 0);
        chk("rnd_ovf", ovf, m_ovf);
        chk("rnd_mis", mis, m_mis);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Sits directly downstream of the reorder buffer's commit port. It accepts committed stores (address, data, SB/SH/SW type) and holds them in a small in-order FIFO.
- It drains that FIFO to data memory over a req/ack handshake.
- It gives the load unit a word-address conflict check, so no load bypasses an older, still-pending committed store.
- Its `empty` output tells the issue stage when no committed store remains outstanding.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, 2..16.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- commitValid  in  1  ROB commits one store this cycle.
- commitAddr  in  32  byte address of the store.
- commitData  in  32  store data, right-aligned.
- commitType  in  3  000=SB, 001=SH, 010=SW; other codes are illegal.
- full  out  1  registered; count==DEPTH.
- empty  out  1  registered; count==0 and no write in flight.
- memReq  out  1  write request to data memory.
- memAddr  out  32  word-aligned address {addr[31:2],2'b00}.
- memData  out  32  lane-replicated write data.
- memByteEn  out  4  byte-lane enables.
- memAck  in  1  memory accepted the write this cycle.
- loadCheckAddr  in  32  byte address of a candidate load.
- loadConflict  out  1  combinational; some pending store has the same word address.
- errOverflow  out  1  sticky; a commit was dropped while full.
- errMisalign  out  1  sticky; a misaligned or illegal-type store was dropped.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - head, tail and count cleared to 0; FSM goes to IDLE.
  - Outputs become: memReq=0, memAddr=0, memData=0, memByteEn=0, full=0, empty=1, errOverflow=0, errMisalign=0.
  - Reset mid-write abandons the in-flight request; memReq is 0 from the following cycle.
- Enqueue: on an edge with commitValid=1 and full=0, the entry is written at tail, tail increments modulo DEPTH and count increments.
  - Enqueue is judged against registered `full`. A commit arriving while full is dropped and sets errOverflow, even if memAck pops an entry in the same cycle.
- Lane formatting happens at enqueue, with a = commitAddr[1:0]:
  - SB: byteEn = 4'b0001<<a; data = {4{commitData[7:0]}}.
  - SH: a[0] must be 0; byteEn = 4'b0011<<(2*a[1]); data = {2{commitData[15:0]}}.
  - SW: a must be 00; byteEn = 4'b1111; data = commitData.
  - A misaligned store or an illegal type is not enqueued and sets errMisalign.
- Drain FSM:
  - IDLE: if count>0, load head entry into memAddr/memData/memByteEn, set memReq=1 and go to REQ (request visible 1 cycle after entry becomes head).
  - REQ: hold memReq and payload stable until memAck=1. On ack, pop head (head+1 mod DEPTH, count-1), set memReq=0 and return to IDLE. This gives a mandatory one-cycle bubble between writes.
  - memAck while memReq=0 is ignored.
- Simultaneous enqueue and ack when not full: count is unchanged and both pointers advance.
- Wrap-around: pointers wrap at DEPTH; count distinguishes full from empty.
- loadConflict:
  - OR over all valid entries (including the one in REQ) of entry.addr[31:2]==loadCheckAddr[31:2].
  - An entry enqueued this cycle is not visible until the next cycle.
- empty = (count==0); an entry in REQ is still counted, so empty stays 0 until its ack.
- Store order to memory is strictly commit order.
- The ROB flush (cataclysm) does not affect this block, because committed stores are architectural.

Test Plan:
1. Reset, then SW addr 0x100 data 0xDEADBEEF, memAck tied 1 → memReq=1 two cycles after commit with memAddr=0x100, memByteEn=1111, memData=0xDEADBEEF; deasserts next cycle; empty=1 after.
2. SB addr 0x203 data 0x000000AB, then SH addr 0x206 data 0x1234 → first write byteEn=1000, memData=0xABABABAB, addr 0x200; second write byteEn=1100, memData=0x12341234, addr 0x204, in order.
3. memAck held 0, commit 5 SW stores (DEPTH=4) → full=1 after 4th; 5th dropped; errOverflow=1; after releasing ack exactly 4 writes emerge in commit order.
4. Commit SW to 0x300, hold ack 0, loadCheckAddr=0x302 → loadConflict=1; loadCheckAddr=0x304 → 0; after ack → 0x302 gives 0.
5. SW addr 0x101 and commitType 011 → nothing enqueued, errMisalign=1, empty stays 1.
6. rst_n=0 for one cycle while memReq=1 with 3 entries → next cycle memReq=0, empty=1, all errors 0; no further writes.
